spram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port RAM macro among NUM_REQ requesters.
- Each requester issues read/write commands on a valid/ready handshake; reads return data on a per-requester response strobe.
- Translates requester polarity (req_wr=1 means write) to the RAM-side convention: ram_wr=0 writes, ram_wr=1 reads. Any cycle with ram_en=0 returns rdata=0 on the next cycle.
- Sits between compute/DMA clients and the scratch RAM in each mesh node.

---
 rtl/spram_arb_pkg.sv | 18 +
 rtl/spram_arbiter_rr_pick.sv | 39 +++
 rtl/spram_arbiter.sv | 155 +++++++++++++++
 tb/tb_spram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: width helpers and the
// RAM-side operation encoding (the RAM macro uses 0 = write, 1 = read).
package spram_arb_pkg;

    localparam logic RAM_OP_WRITE = 1'b0;
    localparam logic RAM_OP_READ  = 1'b1;

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Index width for a requester count (at least one bit).
    function automatic int calc_iw(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/spram_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of 'valid'
// searching upward from 'ptr' with wrap-around. Reusable by any arbiter
// that shares a resource among N clients.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Rotating priority search starting at ptr; first hit wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with optional grant locking and a 1-cycle read response path.
// Optional feature macro: SPRAM_ARB_RSP_REG_EN adds a register stage on
// rsp_valid/rsp_rdata (read latency 2 instead of 1).
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_LOCK   = 16,
    localparam int AW         = calc_aw(DEPTH),
    localparam int IW         = calc_iw(NUM_REQ),
    localparam int CW         = $clog2(MAX_LOCK + 1)
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*AW-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_en,
    output logic                          ram_wr,
    output logic [AW-1:0]                 ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      lock_owner;
    logic               lock_active;
    logic [CW-1:0]      lock_cnt;
    logic [NUM_REQ-1:0] rd_pend;

    logic [NUM_REQ-1:0] valid_gated;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               lock_hit;
    logic               grant_any;
    logic [IW-1:0]      grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [CW-1:0]      cnt_base;
    logic [DATA_WIDTH-1:0] rdata_sel;

    // While reset is asserted nobody may be granted, so the outputs go idle
    // immediately rather than at the next edge.
    assign valid_gated = req_valid & {NUM_REQ{rst_n}};
    assign lock_hit    = rst_n & lock_active & req_valid[lock_owner];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .valid (valid_gated),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Final grant: a live lock owner wins, otherwise the round-robin pick.
    always_comb begin
        grant_oh = '0;
        if (lock_hit) begin
            grant_any            = 1'b1;
            grant_idx            = lock_owner;
            grant_oh[lock_owner] = 1'b1;
        end else begin
            grant_any = pick_any;
            grant_idx = pick_idx;
            grant_oh  = pick_grant;
        end
    end

    // RAM-side command mux; idle bus is a read-polarity op with zero fields.
    always_comb begin
        req_ready = grant_oh;
        ram_en    = grant_any;
        if (grant_any) begin
            ram_wr    = req_wr[grant_idx] ? RAM_OP_WRITE : RAM_OP_READ;
            ram_addr  = req_addr[grant_idx*AW +: AW];
            ram_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            ram_wr    = RAM_OP_READ;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    // A lock run counts from zero unless this grant continues an existing run.
    assign cnt_base = lock_hit ? lock_cnt : '0;

    // Arbitration state: rotate pointer, track lock runs, mark pending reads.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            lock_owner  <= '0;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            rd_pend     <= '0;
        end else begin
            if (grant_any && !lock_hit) begin
                rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
            end else begin
                rr_ptr <= rr_ptr;
            end

            if (grant_any && req_lock[grant_idx] && (cnt_base < CW'(MAX_LOCK - 1))) begin
                lock_active <= 1'b1;
                lock_owner  <= grant_idx;
                lock_cnt    <= cnt_base + CW'(1);
            end else begin
                lock_active <= 1'b0;
                lock_owner  <= lock_owner;
                lock_cnt    <= '0;
            end

            if (grant_any && (req_wr[grant_idx] == 1'b0)) begin
                rd_pend <= grant_oh;
            end else begin
                rd_pend <= '0;
            end
        end
    end

    assign rdata_sel = (|rd_pend) ? ram_rdata : '0;

`ifdef SPRAM_ARB_RSP_REG_EN
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    // Extra response stage for timing closure on the shared read bus.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rd_pend;
            rsp_rdata_q <= rdata_sel;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`else
    assign rsp_valid = rd_pend;
    assign rsp_rdata = rdata_sel;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed testbench for spram_arbiter with a transaction-level reference
// model (grant choice, lock runs, memory contents, response queue).
module tb_spram_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int N     = 4;
    localparam int ML    = 16;
    localparam int AW    = 10;
`ifdef SPRAM_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clock = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wr = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_en;
    logic            ram_wr;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    spram_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_REQ    (N),
        .MAX_LOCK   (ML)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clock = ~clock;

    // Single-port RAM: 0 = write, 1 = read, 1-cycle read latency, 0 otherwise.
    logic [DW-1:0] ram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    end
    always @(posedge clock) begin
        if (ram_en && !ram_wr) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_en && ram_wr) ? ram_mem[ram_addr] : '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_rr = 0;
    int            m_owner = -1;   // -1: no lock held
    int            m_run = 0;      // grants so far in the current lock run
    logic [DW-1:0] m_mem [int];
    logic [N-1:0]  e_v [LAT];
    logic [DW-1:0] e_d [LAT];
    int            glog [$];

    function automatic int model_grant();
        if (m_owner >= 0 && req_valid[m_owner]) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge rst_n) begin
        int g, run, a;
        bit locked;
        if (!rst_n) begin
            m_rr = 0; m_owner = -1; m_run = 0;
            for (int s = 0; s < LAT; s++) begin e_v[s] = '0; e_d[s] = '0; end
        end else begin
            g = model_grant();
            locked = (m_owner >= 0) && req_valid[m_owner];
            for (int s = LAT - 1; s > 0; s--) begin e_v[s] = e_v[s-1]; e_d[s] = e_d[s-1]; end
            e_v[0] = '0; e_d[0] = '0;
            if (g >= 0) begin
                glog.push_back(g);
                a = int'(req_addr[g*AW +: AW]);
                if (req_wr[g]) begin
                    m_mem[a] = req_wdata[g*DW +: DW];
                end else begin
                    e_v[0] = N'(1) << g;
                    e_d[0] = m_mem.exists(a) ? m_mem[a] : '0;
                end
                run = locked ? m_run + 1 : 1;
                if (req_lock[g] && run < ML) begin m_owner = g; m_run = run; end
                else begin m_owner = -1; m_run = 0; end
                if (!locked) m_rr = (g + 1) % N;
            end else begin
                m_owner = -1; m_run = 0;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clock) begin
        int g;
        g = rst_n ? model_grant() : -1;
        if (g >= 0) begin
            check("req_ready", req_ready, N'(1) << g);
            check("ram_en", ram_en, 1);
            check("ram_wr", ram_wr, !req_wr[g]);
            check("ram_addr", ram_addr, req_addr[g*AW +: AW]);
            check("ram_wdata", ram_wdata, req_wdata[g*DW +: DW]);
        end else begin
            check("req_ready_idle", req_ready, 0);
            check("ram_en_idle", ram_en, 0);
            check("ram_wr_idle", ram_wr, 1);
            check("ram_addr_idle", ram_addr, 0);
            check("ram_wdata_idle", ram_wdata, 0);
        end
        check("rsp_valid", rsp_valid, rst_n ? e_v[LAT-1] : '0);
        check("rsp_rdata", rsp_rdata, rst_n ? e_d[LAT-1] : '0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]              = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e;
        // Reset with everyone requesting: outputs must stay idle.
        rst_n = 1'b0;
        req_valid = 4'hF;
        #2;
        check("reset_ready", req_ready, 4'h0);
        check("reset_ram_en", ram_en, 1'b0);
        check("reset_ram_wr", ram_wr, 1'b1);
        check("reset_rsp_valid", rsp_valid, 4'h0);
        req_valid = 4'h0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Scenario 1: write then read-back from requester 0.
        set_req(0, 1'b1, 10'd5, 32'hDEADBEEF);
        req_valid = 4'b0001;
        #1;
        check("s1_wr_ready", req_ready, 4'b0001);
        check("s1_wr_ramwr", ram_wr, 1'b0);
        check("s1_wr_addr", ram_addr, 10'd5);
        check("s1_wr_data", ram_wdata, 32'hDEADBEEF);
        step();
        set_req(0, 1'b0, 10'd5, 32'h0);
        #1;
        check("s1_rd_ramwr", ram_wr, 1'b1);
        step();
        req_valid = 4'b0000;
        #1;
`ifdef SPRAM_ARB_RSP_REG_EN
        check("s1_rsp_early", rsp_valid, 4'b0000);
        step();
        #1;
`endif
        check("s1_rsp_valid", rsp_valid, 4'b0001);
        check("s1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        step();

        // Preload addresses 0..3, ending on requester 3 so rr_ptr wraps to 0.
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, AW'(i), 32'h100 + 32'(i));
            step();
        end
        req_valid = 4'b1000;
        set_req(3, 1'b1, 10'd3, 32'h103);
        step();

        // Scenario 2: all four read continuously; strict rotation 0,1,2,3.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        req_valid = 4'hF;
        glog.delete();
        for (int k = 0; k < 8; k++) begin
            #1;
            e = 4'b0001 << (k % 4);
            check("s2_rotation", req_ready, e);
            step();
        end
        for (int k = 0; k < 8; k++) check("s2_glog", glog[k], k % 4);
        req_valid = 4'h0;
        step(); step();

        // Scenario 3: requester 2 locks with others valid -> 16 grants then 3.
        glog.delete();
        req_lock = 4'b0100;
        req_valid = 4'b0100;
        step();
        req_valid = 4'hF;
        for (int k = 1; k < 20; k++) begin
            if (k == 16) begin
                #1;
                check("s3_after_lock_ready", req_ready, 4'b1000);
            end
            step();
        end
        for (int k = 0; k < 16; k++) check("s3_locked", glog[k], 2);
        check("s3_next", glog[16], 3);
        check("s3_then", glog[17], 0);
        req_valid = 4'h0;
        req_lock = 4'h0;
        step();

        // Scenario 4: locked requester 1 drops after 3 grants -> 2, not 0.
        glog.delete();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, AW'(10 + i), 32'hA0 + 32'(i));
        req_lock = 4'b0010;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0111;
        step(); step();
        req_valid = 4'b0101;
        req_lock = 4'b0000;
        #1;
        check("s4_ready", req_ready, 4'b0100);
        step();
        check("s4_g0", glog[0], 1);
        check("s4_g1", glog[1], 1);
        check("s4_g2", glog[2], 1);
        check("s4_g3", glog[3], 2);
        req_valid = 4'h0;
        step();

        // Scenario 5: reset right after a read is accepted drops the response.
        set_req(0, 1'b0, 10'd5, 32'h0);
        req_valid = 4'b0001;
        step();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        req_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        check("s5_rsp_valid", rsp_valid, 4'h0);
        check("s5_rsp_rdata", rsp_rdata, 32'h0);
        check("s5_ready", req_ready, 4'h0);
        check("s5_ram_en", ram_en, 1'b0);
        check("s5_ram_wr", ram_wr, 1'b1);
        check("s5_ram_addr", ram_addr, 10'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("s5_first_grant", req_ready, 4'b0001);
        step();
        req_valid = 4'h0;
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
